// File: rtl/popcount_pkg.sv
// Shared definitions for the sequential ternary-neuron popcount engine.
package popcount_pkg;

    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcount_chunk #(
    parameter  int CHUNK = 8,
    localparam int OW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [OW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) count = count + OW'(bits[i]);
    end

endmodule

// File: rtl/popcount_tnn_seq.sv
// Multi-cycle ternary neuron: masked +1/-1 popcounts accumulated CHUNK bits
// per cycle, optional count truncation, then a two-threshold ternary decision.
module popcount_tnn_seq #(
    parameter  int N_INPUTS = 22,
    parameter  int CHUNK    = 8,
    parameter  int TRUNC    = 2,
    localparam int CW       = $clog2(N_INPUTS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_INPUTS-1:0] in_x,
    input  logic [N_INPUTS-1:0] in_wpos,
    input  logic [N_INPUTS-1:0] in_wneg,
    input  logic signed [CW:0]  in_thr_hi,
    input  logic signed [CW:0]  in_thr_lo,
    input  logic                in_approx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_pos,
    output logic [CW-1:0]       out_neg,
    output logic [CW:0]         out_sum,
    output logic [1:0]          out_tern
);
    import popcount_pkg::*;

    localparam int NCHUNK = ceil_div(N_INPUTS, CHUNK);
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PCW    = $clog2(CHUNK + 1);
    localparam logic [CW-1:0] KEEP = ~CW'((1 << TRUNC) - 1);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t               state;
    logic [PADW-1:0]      p_cap, m_cap;
    logic signed [CW:0]   thr_hi, thr_lo;
    logic                 approx;
    logic [CW-1:0]        acc_pos, acc_neg;
    logic [IW-1:0]        idx;

    logic [CHUNK-1:0]     p_chunk, m_chunk;
    logic [PCW-1:0]       pc_pos, pc_neg;
    logic [CW-1:0]        pos_f, neg_f;
    logic signed [CW:0]   sum_f;
    logic [1:0]           tern_f;

    assign in_ready = (state == ST_IDLE);
    assign p_chunk  = p_cap[int'(idx) * CHUNK +: CHUNK];
    assign m_chunk  = m_cap[int'(idx) * CHUNK +: CHUNK];

    popcount_chunk #(.CHUNK(CHUNK)) u_pc_pos (.bits(p_chunk), .count(pc_pos));
    popcount_chunk #(.CHUNK(CHUNK)) u_pc_neg (.bits(m_chunk), .count(pc_neg));

    // Upper threshold is tested first so it wins when thr_lo > thr_hi.
    always_comb begin
        pos_f = approx ? (acc_pos & KEEP) : acc_pos;
        neg_f = approx ? (acc_neg & KEEP) : acc_neg;
        sum_f = $signed({1'b0, pos_f}) - $signed({1'b0, neg_f});
        if (sum_f > thr_hi)      tern_f = TERN_POS;
        else if (sum_f < thr_lo) tern_f = TERN_NEG;
        else                     tern_f = TERN_ZERO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            p_cap     <= '0;
            m_cap     <= '0;
            thr_hi    <= '0;
            thr_lo    <= '0;
            approx    <= 1'b0;
            acc_pos   <= '0;
            acc_neg   <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_neg   <= '0;
            out_sum   <= '0;
            out_tern  <= TERN_ZERO;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    // Bits claimed by both masks cancel to zero.
                    p_cap   <= PADW'(in_x & in_wpos & ~in_wneg);
                    m_cap   <= PADW'(in_x & in_wneg & ~in_wpos);
                    thr_hi  <= in_thr_hi;
                    thr_lo  <= in_thr_lo;
                    approx  <= in_approx;
                    acc_pos <= '0;
                    acc_neg <= '0;
                    idx     <= '0;
                    state   <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc_pos <= acc_pos + CW'(pc_pos);
                    acc_neg <= acc_neg + CW'(pc_neg);
                    if (idx == LAST) state <= ST_FINAL;
                    else             idx   <= idx + 1'b1;
                end
                ST_FINAL: begin
                    out_pos   <= pos_f;
                    out_neg   <= neg_f;
                    out_sum   <= sum_f;
                    out_tern  <= tern_f;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
